// File: rtl/seq_alu_if.sv
// Operand/result bundle between the EX stage and seq_alu.
// The master drives start/control/operands; the slave returns results and status.
interface seq_alu_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [3:0]       control;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] r15;
   logic             busy;
   logic             done;
   logic             carry;
   logic             div_zero;

   modport master (
      output start, control, a, b,
      input  op1, r15, busy, done, carry, div_zero
   );

   modport slave (
      input  start, control, a, b,
      output op1, r15, busy, done, carry, div_zero
   );
endinterface

// File: rtl/seq_alu.sv
// Clocked ALU: 1-cycle logic/add/sub, WIDTH-cycle shift-add MUL and restoring DIV; busy stalls EX,
// starts while busy are dropped. SEQ_ALU_SIGNED_EN adds MULS (0100) and DIVS (0101).
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   seq_alu_if.slave    bus
);
   localparam int W  = WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   acc_q, acc_d;   // partial product high half / running remainder
   logic [W-1:0]   mq_q, mq_d;     // multiplier / dividend shifting into quotient
   logic [W-1:0]   dvs_q, dvs_d;   // multiplicand / divisor
   logic [W-1:0]   op1_q, op1_d;
   logic [W-1:0]   r15_q, r15_d;
   logic           carry_q, carry_d;
   logic           div_zero_q, div_zero_d;
   logic           done_q, done_d;
`ifdef SEQ_ALU_SIGNED_EN
   logic           neg_p_q, neg_p_d;
   logic           neg_r_q, neg_r_d;

   function automatic logic [W-1:0] abs_f(input logic [W-1:0] v);
      return v[W-1] ? -v : v;
   endfunction
`endif

   logic [W:0]     add_sum, sub_sum, mul_sum, div_shift;
   logic [2*W-1:0] prod;
   logic [W-1:0]   rem_n, quo_n, s_res, opa, opb;
   logic           div_ge, single, s_carry, go_mul, go_div;

   assign add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{W{1'b0}}, 1'b1};
   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : '0);
   assign prod      = {mul_sum, mq_q[W-1:1]};
   assign div_shift = {acc_q, mq_q[W-1]};
   assign div_ge    = (div_shift >= {1'b0, dvs_q});
   assign rem_n     = div_ge ? (div_shift[W-1:0] - dvs_q) : div_shift[W-1:0];
   assign quo_n     = {mq_q[W-2:0], div_ge};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mq_d       = mq_q;
      dvs_d      = dvs_q;
      op1_d      = op1_q;
      r15_d      = r15_q;
      carry_d    = carry_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      single     = 1'b0;
      s_res      = '0;
      s_carry    = 1'b0;
      go_mul     = 1'b0;
      go_div     = 1'b0;
      opa        = bus.a;
      opb        = bus.b;
`ifdef SEQ_ALU_SIGNED_EN
      neg_p_d    = neg_p_q;
      neg_r_d    = neg_r_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               single = 1'b1;
`ifdef SEQ_ALU_SIGNED_EN
               neg_p_d = 1'b0;
               neg_r_d = 1'b0;
`endif
               case (bus.control)
                  4'b0110:          s_res = bus.a & bus.b;
                  4'b0111:          s_res = bus.a | bus.b;
                  4'b0000, 4'b1000: {s_carry, s_res} = add_sum;
                  4'b0001:          {s_carry, s_res} = sub_sum;
                  4'b0010:          begin single = 1'b0; go_mul = 1'b1; end
                  4'b0011:          begin single = 1'b0; go_div = 1'b1; end
`ifdef SEQ_ALU_SIGNED_EN
                  4'b0100: begin
                     single  = 1'b0;
                     go_mul  = 1'b1;
                     opa     = abs_f(bus.a);
                     opb     = abs_f(bus.b);
                     neg_p_d = bus.a[W-1] ^ bus.b[W-1];
                  end
                  4'b0101: begin
                     single  = 1'b0;
                     go_div  = 1'b1;
                     opa     = abs_f(bus.a);
                     opb     = abs_f(bus.b);
                     neg_p_d = bus.a[W-1] ^ bus.b[W-1];
                     neg_r_d = bus.a[W-1];
                  end
`endif
                  default: ;
               endcase
               if (single) begin
                  op1_d      = s_res;
                  r15_d      = '0;
                  carry_d    = s_carry;
                  div_zero_d = 1'b0;
                  done_d     = 1'b1;
               end
               if (go_div && opb == '0) begin
                  op1_d      = '1;
                  r15_d      = bus.a;
                  carry_d    = 1'b0;
                  div_zero_d = 1'b1;
                  done_d     = 1'b1;
               end else if (go_mul || go_div) begin
                  state_d = go_mul ? S_MUL : S_DIV;
                  cnt_d   = CW'(W);
                  acc_d   = '0;
                  mq_d    = opa;
                  dvs_d   = opb;
               end
            end
         end
         S_MUL: begin
            acc_d = mul_sum[W:1];
            mq_d  = {mul_sum[0], mq_q[W-1:1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d      = S_IDLE;
`ifdef SEQ_ALU_SIGNED_EN
               {r15_d, op1_d} = neg_p_q ? -prod : prod;
`else
               {r15_d, op1_d} = prod;
`endif
               carry_d    = 1'b0;
               div_zero_d = 1'b0;
               done_d     = 1'b1;
            end
         end
         S_DIV: begin
            acc_d = rem_n;
            mq_d  = quo_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d    = S_IDLE;
`ifdef SEQ_ALU_SIGNED_EN
               op1_d      = neg_p_q ? -quo_n : quo_n;
               r15_d      = neg_r_q ? -rem_n : rem_n;
`else
               op1_d      = quo_n;
               r15_d      = rem_n;
`endif
               carry_d    = 1'b0;
               div_zero_d = 1'b0;
               done_d     = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mq_q       <= '0;
         dvs_q      <= '0;
         op1_q      <= '0;
         r15_q      <= '0;
         carry_q    <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef SEQ_ALU_SIGNED_EN
         neg_p_q    <= 1'b0;
         neg_r_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mq_q       <= mq_d;
         dvs_q      <= dvs_d;
         op1_q      <= op1_d;
         r15_q      <= r15_d;
         carry_q    <= carry_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
`ifdef SEQ_ALU_SIGNED_EN
         neg_p_q    <= neg_p_d;
         neg_r_q    <= neg_r_d;
`endif
      end
   end

   assign bus.op1      = op1_q;
   assign bus.r15      = r15_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.carry    = carry_q;
   assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=16): vector table through a result scoreboard, plus
// hand sequences for ignored/back-to-back starts and reset abort.
module tb_seq_alu;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [3:0]   ctl;
      logic [W-1:0] a, b, op1, r15;
      logic         carry, dz;
      int           edges;
   } vec_t;

   typedef struct {
      logic [W-1:0] op1, r15;
      logic         carry, dz;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            chk("spurious_done", 64'(bus.done), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("op1",      64'(bus.op1),      64'(e.op1));
            chk("r15",      64'(bus.r15),      64'(e.r15));
            chk("carry",    64'(bus.carry),    64'(e.carry));
            chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
            chk("busy_in_done", 64'(bus.busy), 64'd0);
         end
      end
   end

   task automatic wait_done(output int edges, output int busy_n);
      edges  = 0;
      busy_n = 0;
      forever begin
         @(negedge clk);
         if (bus.done) break;
         if (bus.busy) busy_n++;
         if (edges > 3 * W) begin
            chk("done_timeout", 64'(bus.done), 64'd1);
            break;
         end
         @(posedge clk);
         edges++;
      end
   endtask

   task automatic launch(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] op1, input logic [W-1:0] r15,
                         input logic carry, input logic dz);
      bus.start   = 1'b1;
      bus.control = ctl;
      bus.a       = a;
      bus.b       = b;
      sb.push_back('{op1: op1, r15: r15, carry: carry, dz: dz});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
   endtask

   task automatic run_vec(input vec_t v);
      int edges, busy_n;
      @(negedge clk);
      launch(v.ctl, v.a, v.b, v.op1, v.r15, v.carry, v.dz);
      wait_done(edges, busy_n);
      chk("latency", 64'(edges), 64'(v.edges));
      chk("busy_cycles", 64'(busy_n), 64'(v.edges));
   endtask

   initial begin
      int edges, busy_n, d0;
      bus.start   = 1'b0;
      bus.control = 4'b0000;
      bus.a       = '0;
      bus.b       = '0;

      //          ctl      a         b         op1       r15       c     dz    edges
      vecs.push_back('{4'b0110, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b0111, 16'hF0F0, 16'h0F01, 16'hFFF1, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 0});
      vecs.push_back('{4'b0000, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b1000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 0});
      vecs.push_back('{4'b0001, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b0001, 16'h0007, 16'h0005, 16'h0002, 16'h0000, 1'b1, 1'b0, 0});
      vecs.push_back('{4'b0001, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 0});
      vecs.push_back('{4'b0010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, W});
      vecs.push_back('{4'b1111, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b0010, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0011, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0011, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 1'b0, 1'b1, 0});
      vecs.push_back('{4'b0110, 16'h00FF, 16'h0F0F, 16'h000F, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b0011, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0011, 16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0011, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 0});
      vecs.push_back('{4'b0010, 16'h0003, 16'h0004, 16'h000C, 16'h0000, 1'b0, 1'b0, W});
`ifdef SEQ_ALU_SIGNED_EN
      vecs.push_back('{4'b0100, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0101, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0101, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0, W});
      vecs.push_back('{4'b0101, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b0, 1'b1, 0});
`else
      vecs.push_back('{4'b0100, 16'hFFFD, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 0});
      vecs.push_back('{4'b0101, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0, 0});
`endif

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_outputs", 64'({bus.op1, bus.r15, bus.busy, bus.done, bus.carry, bus.div_zero}), 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // MUL with an ignored mid-run start, then an ADD accepted in the done cycle.
      @(negedge clk);
      launch(4'b0010, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.control = 4'b0000; bus.a = 16'h0001; bus.b = 16'h0001;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(edges, busy_n);
      chk("mul_latency", 64'(edges), 64'(W - 4));
      launch(4'b0000, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_done", 64'(bus.done), 64'd1);

      // Reset eight cycles into a MUL: abort, no done, then normal operation.
      @(negedge clk);
      launch(4'b0010, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      #1;
      chk("abort_outputs", 64'({bus.op1, bus.r15, bus.busy, bus.done, bus.carry, bus.div_zero}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(d0));
      chk("abort_busy", 64'(bus.busy), 64'd0);
      run_vec('{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 0});

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected end earlier", $time);
      $fatal(1, "watchdog");
   end
endmodule
